decode_scoreboard: RTL and testbench

Parametrised per-register hazard scoreboard for the decode stage, generalising the fixed load-use and branch stall logic. It tracks the number of cycles until each in-flight destination register becomes forwardable. It produces decode stall and per-source hazard flags for ALU/store consumers and for decode-resolved register branches. Producer latency is variable per instruction, so multi-cycle loads and long-latency units are supported without changing the stall logic.

---
 rtl/decode_scoreboard.sv | 95 +++++++++
 tb/tb_decode_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard scoreboard: per-register countdown to forwardability, decode stall and hazard flags.
// Optional macro SB_BRANCH_EXFWD_EN lets register branches consume a latency-0 result from the EX bypass.
module decode_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4,
    parameter int MAX_LAT  = 3,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic                flush,
    input  logic                dec_wr,
    input  logic [REG_AW-1:0]   dec_dst,
    input  logic [CNT_W-1:0]    dec_lat,
    input  logic [REG_AW-1:0]   src1,
    input  logic [REG_AW-1:0]   src2,
    input  logic                src1_used,
    input  logic                src2_used,
    input  logic                br_reg,
    output logic                stall,
    output logic                haz1,
    output logic                haz2,
    output logic [NUM_REGS-1:0] busy,
    output logic [PERF_W-1:0]   stall_total
);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] lat_c;
    logic [CNT_W-1:0] cnt_new;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             issue;
    logic             br_ok;
    logic             br_blk;

    assign lat_c   = (dec_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : dec_lat;
    assign cnt_new = lat_c + CNT_W'(1);
    assign cnt1    = cnt[src1];
    assign cnt2    = cnt[src2];

`ifdef SB_BRANCH_EXFWD_EN
    logic exf [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) exf[r] <= 1'b0;
        end else begin
            exf[0] <= 1'b0;
            for (int unsigned r = 1; r < NUM_REGS; r++)
                if (issue && dec_dst == REG_AW'(r)) exf[r] <= (dec_lat == '0);
        end
    end

    assign br_ok = exf[src1];
`else
    assign br_ok = 1'b0;
`endif

    // A branch resolves in decode, so a count of 1 still blocks unless the EX bypass can serve it.
    assign br_blk = (cnt1 > CNT_W'(1)) | ((cnt1 == CNT_W'(1)) & ~br_ok);

    always_comb begin
        haz1 = 1'b0;
        if (src1 != '0) begin
            if (br_reg) haz1 = br_blk;
            else        haz1 = src1_used & (cnt1 > CNT_W'(1));
        end
        haz2  = src2_used & (src2 != '0) & (cnt2 > CNT_W'(1));
        stall = dec_valid & ~flush & (haz1 | haz2);
        issue = dec_valid & ~flush & ~stall & dec_wr & (dec_dst != '0);
    end

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
    end

    // Issue overwrites an older pending entry for the same register (WAW).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            stall_total <= '0;
        end else begin
            cnt[0] <= '0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (issue && dec_dst == REG_AW'(r)) cnt[r] <= cnt_new;
                else if (cnt[r] != '0)              cnt[r] <= cnt[r] - CNT_W'(1);
            end
            if (stall && stall_total != '1) stall_total <= stall_total + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed hazard scenarios plus random traffic against a ready-time model.
module tb_decode_scoreboard;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int ML = 3;
    localparam int CW = 3;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid, flush, dec_wr, src1_used, src2_used, br_reg;
    logic [AW-1:0] dec_dst, src1, src2;
    logic [CW-1:0] dec_lat;
    logic          stall, haz1, haz2;
    logic [NR-1:0] busy;
    logic [PW-1:0] stall_total;

    always #5 clk = ~clk;

    decode_scoreboard #(.NUM_REGS(NR), .REG_AW(AW), .MAX_LAT(ML), .CNT_W(CW), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .flush(flush), .dec_wr(dec_wr),
        .dec_dst(dec_dst), .dec_lat(dec_lat), .src1(src1), .src2(src2),
        .src1_used(src1_used), .src2_used(src2_used), .br_reg(br_reg),
        .stall(stall), .haz1(haz1), .haz2(haz2), .busy(busy), .stall_total(stall_total)
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint ready_at [NR];
    bit     alu_prod [NR];
    int     total_m  = 0;

    // Cycles remaining until register r is forwardable, derived from its absolute ready time.
    function automatic int cnt_m(input int r);
        if (r == 0) return 0;
        if (ready_at[r] > cyc) return int'(ready_at[r] - cyc);
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            ready_at[r] = 0;
            alu_prod[r] = 1'b0;
        end
        total_m = 0;
    endtask

    task automatic step(input logic v, input logic fl, input logic wr, input logic [AW-1:0] dst,
                        input logic [CW-1:0] lat, input logic [AW-1:0] s1, input logic u1,
                        input logic [AW-1:0] s2, input logic u2, input logic br, output logic st);
        int c1, c2, lc;
        bit ok, h1, h2, s;
        logic [NR-1:0] b;
        dec_valid = v; flush = fl; dec_wr = wr; dec_dst = dst; dec_lat = lat;
        src1 = s1; src1_used = u1; src2 = s2; src2_used = u2; br_reg = br;
        @(negedge clk);
        c1 = cnt_m(int'(s1));
        c2 = cnt_m(int'(s2));
`ifdef SB_BRANCH_EXFWD_EN
        ok = (c1 == 1) && alu_prod[s1];
`else
        ok = 1'b0;
`endif
        h1 = (s1 != 0) && (br ? (c1 > 1 || (c1 == 1 && !ok)) : (u1 && c1 > 1));
        h2 = u2 && (s2 != 0) && (c2 > 1);
        s  = v && !fl && (h1 || h2);
        for (int r = 0; r < NR; r++) b[r] = (cnt_m(r) != 0);
        chk("haz1", 32'(haz1), 32'(h1));
        chk("haz2", 32'(haz2), 32'(h2));
        chk("stall", 32'(stall), 32'(s));
        chk("busy", 32'(busy), 32'(b));
        chk("stall_total", 32'(stall_total), 32'(total_m));
        st = s;
        @(posedge clk);
        if (v && !fl && !s && wr && dst != 0) begin
            lc = (int'(lat) > ML) ? ML : int'(lat);
            ready_at[dst] = cyc + 1 + lc + 1;
            alu_prod[dst] = (lat == 0);
        end
        if (s && total_m < (1 << PW) - 1) total_m++;
        cyc++;
        #1;
    endtask

    // Present one instruction until it issues; reports how many cycles it stalled.
    task automatic instr(input logic wr, input logic [AW-1:0] dst, input logic [CW-1:0] lat,
                         input logic [AW-1:0] s1, input logic u1, input logic [AW-1:0] s2,
                         input logic u2, input logic br, output int nst);
        logic st;
        nst = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, wr, dst, lat, s1, u1, s2, u2, br, st);
            if (!st) break;
            nst++;
        end
    endtask

    task automatic idle();
        logic st;
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, st);
    endtask

    initial begin
        int   nst, t0;
        logic st;
        rst_n = 1'b0;
        dec_valid = 0; flush = 0; dec_wr = 0; dec_dst = '0; dec_lat = '0;
        src1 = '0; src2 = '0; src1_used = 0; src2_used = 0; br_reg = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_total", 32'(stall_total), 32'd0);
        rst_n = 1'b1;
        idle();

        // Load then dependent ALU op.
        t0 = total_m;
        instr(1, 4'd3, 3'd1, 4'd0, 0, 4'd0, 0, 0, nst);
        instr(0, 4'd0, 3'd0, 4'd3, 1, 4'd0, 0, 0, nst);
        chk("ld_alu_stalls", 32'(nst), 32'd1);
        chk("ld_alu_total", 32'(stall_total), 32'(t0 + 1));
        repeat (3) idle();

        // Load then dependent register branch.
        t0 = total_m;
        instr(1, 4'd3, 3'd1, 4'd0, 0, 4'd0, 0, 0, nst);
        instr(0, 4'd0, 3'd0, 4'd3, 0, 4'd0, 0, 1, nst);
        chk("ld_br_stalls", 32'(nst), 32'd2);
        chk("ld_br_total", 32'(stall_total), 32'(t0 + 2));
        repeat (3) idle();

        // ALU then dependent register branch.
        instr(1, 4'd5, 3'd0, 4'd0, 0, 4'd0, 0, 0, nst);
        instr(0, 4'd0, 3'd0, 4'd5, 0, 4'd0, 0, 1, nst);
`ifdef SB_BRANCH_EXFWD_EN
        chk("alu_br_stalls", 32'(nst), 32'd0);
`else
        chk("alu_br_stalls", 32'(nst), 32'd1);
`endif
        repeat (3) idle();

        // Writes to r0 never create a hazard.
        instr(1, 4'd0, 3'd3, 4'd0, 0, 4'd0, 0, 0, nst);
        instr(0, 4'd0, 3'd0, 4'd0, 1, 4'd0, 1, 1, nst);
        chk("r0_stalls", 32'(nst), 32'd0);
        chk("r0_busy", 32'(busy), 32'd0);

        // Latency clamp: 7 behaves as MAX_LAT.
        instr(1, 4'd4, 3'd7, 4'd0, 0, 4'd0, 0, 0, nst);
        instr(0, 4'd0, 3'd0, 4'd0, 0, 4'd4, 1, 0, nst);
        chk("clamp_stalls", 32'(nst), 32'd3);
        repeat (3) idle();

        // Flush in the second stall cycle of a latency-3 load.
        instr(1, 4'd2, 3'd3, 4'd0, 0, 4'd0, 0, 0, nst);
        step(1, 0, 1, 4'd9, 3'd0, 4'd2, 1, 4'd0, 0, 0, st);
        chk("fl_stall1", 32'(st), 32'd1);
        step(1, 1, 1, 4'd9, 3'd0, 4'd2, 1, 4'd0, 0, 0, st);
        chk("fl_busy9", 32'(busy[9]), 32'd0);
        step(1, 0, 1, 4'd9, 3'd0, 4'd2, 1, 4'd0, 0, 0, st);
        chk("fl_stall3", 32'(st), 32'd1);
        step(1, 0, 1, 4'd9, 3'd0, 4'd2, 1, 4'd0, 0, 0, st);
        chk("fl_issue", 32'(st), 32'd0);
        idle();
        chk("fl_busy2_clear", 32'(busy[2]), 32'd0);
        repeat (3) idle();

        // Random traffic over a few registers so dependencies are frequent.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 5)), CW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, st);
        end

        // Reset asserted in the middle of a stall.
        repeat (4) idle();
        instr(1, 4'd2, 3'd3, 4'd0, 0, 4'd0, 0, 0, nst);
        step(1, 0, 1, 4'd7, 3'd2, 4'd2, 1, 4'd0, 0, 0, st);
        chk("pre_rst_stall", 32'(st), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_total", 32'(stall_total), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_no_issue", 32'(busy), 32'd0);
        rst_n = 1'b1;
        model_reset();
        idle();

        // Saturation: a self-dependent load keeps re-arming its own stall.
        for (int i = 0; i < 400; i++) step(1, 0, 1, 4'd2, 3'd7, 4'd2, 1, 4'd0, 0, 0, st);
        chk("sat_total", 32'(stall_total), 32'((1 << PW) - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
